// File: rtl/letter_flow_gen_pkg.sv
// Shared constants and LFSR helpers for the letter stream generator.
package letter_flow_gen_pkg;

  localparam logic [7:0]  CH_SPACE = 8'h20;
  localparam logic [7:0]  CH_A     = 8'h41;
  localparam logic [7:0]  CH_a     = 8'h61;
  localparam int          LETTERS  = 26;
  localparam logic [15:0] LFSR_MASK        = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED_CAP = 16'hACE1;
  localparam logic [15:0] DEFAULT_SEED_LOW = 16'h1D0F;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

  // Fold the 5-bit tap range 0..31 onto 0..25 with one subtract.
  function automatic logic [4:0] lfsr_letter(input logic [15:0] s);
    logic [4:0] r;
    r = s[4:0];
    return (r >= 5'(LETTERS)) ? r - 5'(LETTERS) : r;
  endfunction

endpackage

// File: rtl/letter_flow_gen_lfsr16.sv
// 16-bit Galois right-shift LFSR; loads its seed on reset, steps when adv is high.
module lfsr16
  import letter_flow_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] seed,
  input  logic        adv,
  output logic [15:0] state
);

  logic [15:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (adv) state_d = lfsr_next(state_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= seed;
    else        state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/letter_flow_gen.sv
// Uppercase/lowercase ASCII stimulus generator with sweep and LFSR modes and a tick divider.
module letter_flow_gen
  import letter_flow_gen_pkg::*;
#(
  parameter int unsigned DIV      = 1,
  parameter int unsigned LOW_STEP = 1,
  parameter logic [15:0] SEED_CAP = 16'hACE1,
  parameter logic [15:0] SEED_LOW = 16'h1D0F
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       mode,
  output logic [7:0] cap_flow,
  output logic [7:0] low_flow,
  output logic       flow_valid
);

  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
  localparam logic [4:0]  STEP     = 5'(LOW_STEP % LETTERS);
  // An all-zero seed would lock the LFSR, so fall back to the defaults.
  localparam logic [15:0] SEED_CAP_EFF = (SEED_CAP == 16'h0) ? DEFAULT_SEED_CAP : SEED_CAP;
  localparam logic [15:0] SEED_LOW_EFF = (SEED_LOW == 16'h0) ? DEFAULT_SEED_LOW : SEED_LOW;

  logic [15:0] div_cnt_q, div_cnt_d;
  logic [4:0]  cap_idx_q, cap_idx_d;
  logic [4:0]  low_idx_q, low_idx_d;
  logic [7:0]  cap_q, cap_d;
  logic [7:0]  low_q, low_d;
  logic        valid_q, valid_d;
  logic        tick;
  logic        lfsr_adv;
  logic [5:0]  low_sum;
  logic [15:0] lfsr_cap_s, lfsr_low_s;

  assign tick     = en && (div_cnt_q == DIV_LAST);
  assign lfsr_adv = tick && mode;
  assign low_sum  = {1'b0, low_idx_q} + {1'b0, STEP};

  lfsr16 u_cap_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (SEED_CAP_EFF),
    .adv   (lfsr_adv),
    .state (lfsr_cap_s)
  );

  lfsr16 u_low_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (SEED_LOW_EFF),
    .adv   (lfsr_adv),
    .state (lfsr_low_s)
  );

  always_comb begin
    div_cnt_d = div_cnt_q;
    cap_idx_d = cap_idx_q;
    low_idx_d = low_idx_q;
    cap_d     = cap_q;
    low_d     = low_q;
    valid_d   = tick;
    if (en) div_cnt_d = tick ? 16'h0 : div_cnt_q + 16'd1;
    if (tick) begin
      if (mode) begin
        cap_d = CH_A + {3'b000, lfsr_letter(lfsr_cap_s)};
        low_d = CH_a + {3'b000, lfsr_letter(lfsr_low_s)};
      end else begin
        cap_d     = CH_A + {3'b000, cap_idx_q};
        low_d     = CH_a + {3'b000, low_idx_q};
        cap_idx_d = (cap_idx_q == 5'(LETTERS - 1)) ? 5'd0 : cap_idx_q + 5'd1;
        low_idx_d = (low_sum >= 6'(LETTERS)) ? 5'(low_sum - 6'(LETTERS)) : low_sum[4:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q <= 16'h0;
      cap_idx_q <= 5'd0;
      low_idx_q <= 5'd0;
      cap_q     <= CH_SPACE;
      low_q     <= CH_SPACE;
      valid_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      cap_idx_q <= cap_idx_d;
      low_idx_q <= low_idx_d;
      cap_q     <= cap_d;
      low_q     <= low_d;
      valid_q   <= valid_d;
    end
  end

  assign cap_flow   = cap_q;
  assign low_flow   = low_q;
  assign flow_valid = valid_q;

endmodule

// File: tb/tb_letter_flow_gen.sv
// Scoreboard bench: instance 0 runs DIV=1, instance 1 runs DIV=4 with LOW_STEP=7 and a zero low seed.
module tb_letter_flow_gen;

  typedef struct packed { logic [7:0] cap; logic [7:0] low; } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n0, en0, mode0, vld0;
  logic rst_n1, en1, mode1, vld1;
  logic [7:0] cap0, low0, cap1, low1;

  letter_flow_gen #(.DIV(1), .LOW_STEP(1)) u_d0 (
    .clk(clk), .rst_n(rst_n0), .en(en0), .mode(mode0),
    .cap_flow(cap0), .low_flow(low0), .flow_valid(vld0)
  );

  letter_flow_gen #(.DIV(4), .LOW_STEP(7), .SEED_CAP(16'hACE1), .SEED_LOW(16'h0000)) u_d4 (
    .clk(clk), .rst_n(rst_n1), .en(en1), .mode(mode1),
    .cap_flow(cap1), .low_flow(low1), .flow_valid(vld1)
  );

  exp_t q0[$];
  exp_t q1[$];
  int tests = 0;
  int fails = 0;

  int          m_div[2];
  int          m_ci[2];
  int          m_li[2];
  logic [15:0] m_lc[2];
  logic [15:0] m_ll[2];
  logic        m_vld[2];
  logic [7:0]  m_cap[2];
  logic [7:0]  m_low[2];

  function automatic int div_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic int step_of(input int k);
    return (k == 0) ? 1 : 7;
  endfunction

  function automatic logic [15:0] m_adv(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [7:0] m_letter(input logic [15:0] s, input logic [7:0] base);
    int r;
    r = int'(s[4:0]);
    if (r >= 26) r = r - 26;
    return base + 8'(r);
  endfunction

  task automatic model_edge(input int k, input logic r, input logic e, input logic m);
    exp_t x;
    if (!r) begin
      m_div[k] = 0; m_ci[k] = 0; m_li[k] = 0;
      m_lc[k] = 16'hACE1; m_ll[k] = 16'h1D0F;
      m_vld[k] = 1'b0; m_cap[k] = 8'h20; m_low[k] = 8'h20;
      if (k == 0) q0.delete(); else q1.delete();
    end else if (!e) begin
      m_vld[k] = 1'b0;
    end else if (m_div[k] == div_of(k) - 1) begin
      m_vld[k] = 1'b1;
      m_div[k] = 0;
      if (m) begin
        m_cap[k] = m_letter(m_lc[k], 8'h41);
        m_low[k] = m_letter(m_ll[k], 8'h61);
        m_lc[k]  = m_adv(m_lc[k]);
        m_ll[k]  = m_adv(m_ll[k]);
      end else begin
        m_cap[k] = 8'h41 + 8'(m_ci[k]);
        m_low[k] = 8'h61 + 8'(m_li[k]);
        m_ci[k]  = (m_ci[k] + 1) % 26;
        m_li[k]  = (m_li[k] + step_of(k)) % 26;
      end
      x.cap = m_cap[k];
      x.low = m_low[k];
      if (k == 0) q0.push_back(x); else q1.push_back(x);
    end else begin
      m_div[k] = m_div[k] + 1;
      m_vld[k] = 1'b0;
    end
  endtask

  task automatic step();
    model_edge(0, rst_n0, en0, mode0);
    model_edge(1, rst_n1, en1, mode1);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n0 = 1'b0; rst_n1 = 1'b0;
    step(); step();
    tests += 6;
    if (cap0 !== 8'h20) begin fails++; $display("FAIL reset_cap0 got %h exp 20", cap0); end
    if (low0 !== 8'h20) begin fails++; $display("FAIL reset_low0 got %h exp 20", low0); end
    if (vld0 !== 1'b0)  begin fails++; $display("FAIL reset_vld0 got %b exp 0", vld0); end
    if (cap1 !== 8'h20) begin fails++; $display("FAIL reset_cap1 got %h exp 20", cap1); end
    if (low1 !== 8'h20) begin fails++; $display("FAIL reset_low1 got %h exp 20", low1); end
    if (vld1 !== 1'b0)  begin fails++; $display("FAIL reset_vld1 got %b exp 0", vld1); end
    rst_n0 = 1'b1; rst_n1 = 1'b1;
    step();
    tests++;
    if (vld0 !== 1'b0 || cap0 !== 8'h20) begin fails++; $display("FAIL reset_idle got %b/%h exp 0/20", vld0, cap0); end
  endtask

  task automatic test_sweep_div1();
    exp_t e;
    en0 = 1'b1; mode0 = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      step();
      tests++;
      if (vld0 !== 1'b1) begin fails++; $display("FAIL sweep_valid cyc %0d got %b exp 1", i, vld0); end
      if (vld0 === 1'b1) begin
        tests++;
        if (q0.size() == 0) begin fails++; $display("FAIL sweep_sb cyc %0d got output exp none", i); end
        else begin
          e = q0.pop_front();
          if ({cap0, low0} !== {e.cap, e.low}) begin
            fails++; $display("FAIL sweep_data cyc %0d got %h/%h exp %h/%h", i, cap0, low0, e.cap, e.low);
          end
        end
      end
      if (i == 1 || i == 26 || i == 27) begin
        tests++;
        e.cap = (i == 26) ? 8'h5A : 8'h41;
        e.low = (i == 26) ? 8'h7A : 8'h61;
        if (cap0 !== e.cap || low0 !== e.low) begin
          fails++; $display("FAIL sweep_edge cyc %0d got %h/%h exp %h/%h", i, cap0, low0, e.cap, e.low);
        end
      end
    end
    en0 = 1'b0;
    step();
  endtask

  // DIV=4 stepping, en hold, mode sampled only at a tick.
  task automatic test_div4_hold();
    exp_t e;
    int pulses = 0;
    logic [7:0] want_cap, want_low;
    rst_n1 = 1'b0; step(); rst_n1 = 1'b1;
    en1 = 1'b1; mode1 = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      if (i >= 13 && i <= 17) en1 = 1'b0;
      else en1 = 1'b1;
      mode1 = (i == 23 || i == 24) ? 1'b1 : 1'b0;
      step();
      tests++;
      if (vld1 !== m_vld[1]) begin fails++; $display("FAIL div4_valid cyc %0d got %b exp %b", i, vld1, m_vld[1]); end
      if (vld1 === 1'b1) begin
        tests += 2;
        if (q1.size() == 0) begin fails++; $display("FAIL div4_sb cyc %0d got output exp none", i); end
        else begin
          e = q1.pop_front();
          if ({cap1, low1} !== {e.cap, e.low}) begin
            fails++; $display("FAIL div4_data cyc %0d got %h/%h exp %h/%h", i, cap1, low1, e.cap, e.low);
          end
        end
        want_cap = 8'h41 + 8'(pulses);
        want_low = 8'h61 + 8'((pulses * 7) % 26);
        if (cap1 !== want_cap || low1 !== want_low) begin
          fails++; $display("FAIL div4_letter pulse %0d got %h/%h exp %h/%h", pulses, cap1, low1, want_cap, want_low);
        end
        pulses++;
      end else if (i >= 13 && i <= 17) begin
        tests++;
        if (cap1 !== 8'h43) begin fails++; $display("FAIL en_hold cyc %0d got %h exp 43", i, cap1); end
      end
    end
    tests++;
    if (pulses != 5) begin fails++; $display("FAIL div4_pulses got %0d exp 5", pulses); end
    en1 = 1'b0; mode1 = 1'b0;
    step();
  endtask

  task automatic test_seed_zero();
    exp_t e;
    int pulses = 0;
    rst_n1 = 1'b0; step(); rst_n1 = 1'b1;
    en1 = 1'b1; mode1 = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (vld1 === 1'b1) begin
        tests++;
        if (q1.size() == 0) begin fails++; $display("FAIL seed0_sb cyc %0d got output exp none", i); end
        else begin
          e = q1.pop_front();
          if ({cap1, low1} !== {e.cap, e.low}) begin
            fails++; $display("FAIL seed0_data cyc %0d got %h/%h exp %h/%h", i, cap1, low1, e.cap, e.low);
          end
        end
        if (pulses == 0) begin
          tests++;
          if (cap1 !== 8'h42 || low1 !== 8'h70) begin
            fails++; $display("FAIL seed0_first got %h/%h exp 42/70", cap1, low1);
          end
        end
        pulses++;
      end
    end
    tests++;
    if (pulses != 10) begin fails++; $display("FAIL seed0_pulses got %0d exp 10", pulses); end
    en1 = 1'b0; mode1 = 1'b0;
    step();
  endtask

  task automatic test_lfsr();
    exp_t e;
    int bad_range = 0;
    int zero_state = 0;
    rst_n0 = 1'b0; step(); rst_n0 = 1'b1;
    en0 = 1'b1;
    for (int i = 1; i <= 1040; i++) begin
      mode0 = (i > 1000 && i <= 1010) ? 1'b0 : 1'b1;
      step();
      tests++;
      if (vld0 !== 1'b1) begin fails++; $display("FAIL lfsr_valid cyc %0d got %b exp 1", i, vld0); end
      if (vld0 === 1'b1) begin
        tests++;
        if (q0.size() == 0) begin fails++; $display("FAIL lfsr_sb cyc %0d got output exp none", i); end
        else begin
          e = q0.pop_front();
          if ({cap0, low0} !== {e.cap, e.low}) begin
            fails++; $display("FAIL lfsr_data cyc %0d got %h/%h exp %h/%h", i, cap0, low0, e.cap, e.low);
          end
        end
      end
      if (cap0 < 8'h41 || cap0 > 8'h5A || low0 < 8'h61 || low0 > 8'h7A) bad_range++;
      if (u_d0.lfsr_cap_s == 16'h0 || u_d0.lfsr_low_s == 16'h0) zero_state++;
      if (i == 1 || i == 1001) begin
        tests++;
        if (cap0 !== 8'h42 && i == 1) begin fails++; $display("FAIL lfsr_first got %h exp 42", cap0); end
        if (cap0 !== 8'h41 && i == 1001) begin fails++; $display("FAIL lfsr_to_sweep got %h exp 41", cap0); end
      end
    end
    tests += 2;
    if (bad_range != 0)  begin fails++; $display("FAIL lfsr_range got %0d out-of-range exp 0", bad_range); end
    if (zero_state != 0) begin fails++; $display("FAIL lfsr_zero got %0d zero states exp 0", zero_state); end
    en0 = 1'b0; mode0 = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int cyc = 0;
    rst_n0 = 1'b0; step(); rst_n0 = 1'b1;
    en0 = 1'b1; mode0 = 1'b0;
    while (cap0 !== 8'h4D && cyc < 40) begin
      step();
      cyc++;
      if (vld0 === 1'b1 && q0.size() != 0) begin
        e = q0.pop_front();
        tests++;
        if ({cap0, low0} !== {e.cap, e.low}) begin
          fails++; $display("FAIL rmid_data cyc %0d got %h/%h exp %h/%h", cyc, cap0, low0, e.cap, e.low);
        end
      end
    end
    tests++;
    if (cyc != 13) begin fails++; $display("FAIL rmid_reach_M got %0d cycles exp 13", cyc); end
    rst_n0 = 1'b0;
    step();
    tests++;
    if (cap0 !== 8'h20 || low0 !== 8'h20 || vld0 !== 1'b0) begin
      fails++; $display("FAIL rmid_reset got %h/%h/%b exp 20/20/0", cap0, low0, vld0);
    end
    rst_n0 = 1'b1;
    step();
    tests++;
    if (cap0 !== 8'h41 || low0 !== 8'h61 || vld0 !== 1'b1) begin
      fails++; $display("FAIL rmid_restart got %h/%h/%b exp 41/61/1", cap0, low0, vld0);
    end
    if (q0.size() != 0) void'(q0.pop_front());
    en0 = 1'b0;
    step();
  endtask

  // Walk "I Love You!" against the two streams; space and '!' come from the checker itself.
  task automatic test_phrase();
    exp_t e;
    string phrase = "I Love You!";
    int ptr = 0;
    byte c;
    rst_n0 = 1'b0; step(); rst_n0 = 1'b1;
    en0 = 1'b1; mode0 = 1'b0;
    for (int i = 1; i <= 26 * 11; i++) begin
      step();
      if (vld0 === 1'b1) begin
        tests++;
        if (q0.size() == 0) begin fails++; $display("FAIL phrase_sb cyc %0d got output exp none", i); end
        else begin
          e = q0.pop_front();
          if ({cap0, low0} !== {e.cap, e.low}) begin
            fails++; $display("FAIL phrase_data cyc %0d got %h/%h exp %h/%h", i, cap0, low0, e.cap, e.low);
          end
        end
        while (ptr < phrase.len() && (phrase[ptr] == " " || phrase[ptr] == "!")) ptr++;
        if (ptr < phrase.len()) begin
          c = phrase[ptr];
          if (cap0 == 8'(c) || low0 == 8'(c)) ptr++;
        end
        while (ptr < phrase.len() && (phrase[ptr] == " " || phrase[ptr] == "!")) ptr++;
      end
    end
    tests++;
    if (ptr != phrase.len()) begin fails++; $display("FAIL phrase_walk got %0d chars exp %0d", ptr, phrase.len()); end
    en0 = 1'b0;
    step();
  endtask

  initial begin
    rst_n0 = 1'b0; en0 = 1'b0; mode0 = 1'b0;
    rst_n1 = 1'b0; en1 = 1'b0; mode1 = 1'b0;
    test_reset();
    test_sweep_div1();
    test_div4_hold();
    test_seed_zero();
    test_lfsr();
    test_reset_mid();
    test_phrase();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
